// File: rtl/stream_merge_rr.sv
// 2:1 valid/ready stream merger with round-robin arbitration and burst lock.
// Output beat is registered; input readies are combinational from grant and load.
module stream_merge_rr #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_src,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e           state_q;
  logic             prio_q;

  logic             load_c;
  logic             grant_vld_c;
  logic             grant_src_c;
  logic             accept_c;
  logic [WIDTH-1:0] sel_data_c;
  logic             sel_last_c;

  // Grant selection: locked source wins outright, otherwise valid/prio arbitration.
  always_comb begin
    load_c      = !out_valid || out_ready;
    grant_vld_c = 1'b0;
    grant_src_c = 1'b0;
    unique case (state_q)
      LOCK0: begin
        grant_vld_c = 1'b1;
        grant_src_c = 1'b0;
      end
      LOCK1: begin
        grant_vld_c = 1'b1;
        grant_src_c = 1'b1;
      end
      default: begin
        if (in0_valid && in1_valid) begin
          grant_vld_c = 1'b1;
          grant_src_c = prio_q;
        end else if (in0_valid) begin
          grant_vld_c = 1'b1;
          grant_src_c = 1'b0;
        end else if (in1_valid) begin
          grant_vld_c = 1'b1;
          grant_src_c = 1'b1;
        end
      end
    endcase

    in0_ready  = !rst && load_c && grant_vld_c && !grant_src_c;
    in1_ready  = !rst && load_c && grant_vld_c && grant_src_c;
    accept_c   = (in0_ready && in0_valid) || (in1_ready && in1_valid);
    sel_data_c = grant_src_c ? in1_data : in0_data;
    sel_last_c = grant_src_c ? in1_last : in0_last;
  end

  // Output register, lock state and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= 1'b0;
    end else begin
      if (load_c) begin
        out_valid <= accept_c;
      end
      if (accept_c) begin
        out_data <= sel_data_c;
        out_last <= sel_last_c;
        out_src  <= grant_src_c;
        if (sel_last_c) begin
          state_q <= IDLE;
          prio_q  <= !grant_src_c;
        end else begin
          state_q <= grant_src_c ? LOCK1 : LOCK0;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_merge_rr.sv
// Directed bench for stream_merge_rr: driver pushes expected beats into a queue,
// a negedge monitor pops and compares every output handshake.
module tb_stream_merge_rr;

  logic       clk;
  logic       rst;
  logic       in0_valid, in0_last, in0_ready;
  logic [7:0] in0_data;
  logic       in1_valid, in1_last, in1_ready;
  logic [7:0] in1_data;
  logic       out_valid, out_last, out_src, out_ready;
  logic [7:0] out_data;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  stream_merge_rr #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_last  (in0_last),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_last  (in1_last),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic l, input logic s);
    exp_q.push_back({s, l, d});
  endtask

  // One cycle: drive inputs, check readies and out_valid at negedge, advance past posedge.
  task automatic step(input logic r, input logic v0, input logic [7:0] d0, input logic l0,
                      input logic v1, input logic [7:0] d1, input logic l1, input logic ordy,
                      input logic er0, input logic er1, input logic ev);
    rst = r;
    in0_valid = v0; in0_data = d0; in0_last = l0;
    in1_valid = v1; in1_data = d1; in1_last = l1;
    out_ready = ordy;
    @(negedge clk);
    chk("in0_ready", 32'(in0_ready), 32'(er0));
    chk("in1_ready", 32'(in1_ready), 32'(er1));
    chk("out_valid", 32'(out_valid), 32'(ev));
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every downstream handshake must match the next expected beat.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got data=0x%0h last=%0d src=%0d, none expected",
                 out_data, out_last, out_src);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({out_src, out_last, out_data} !== e) begin
          errors++;
          $display("FAIL beat: got data=0x%0h last=%0d src=%0d expected data=0x%0h last=%0d src=%0d",
                   out_data, out_last, out_src, e[7:0], e[8], e[9]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    in0_valid = 1'b1; in0_data = 8'hAA; in0_last = 1'b1;
    in1_valid = 1'b1; in1_data = 8'hBB; in1_last = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset with both sources valid: nothing accepted, no output.
    step(1, 1, 8'hAA, 1, 1, 8'hBB, 1, 1, 0, 0, 0);
    step(1, 1, 8'hAA, 1, 1, 8'hBB, 1, 1, 0, 0, 0);

    // Tie round-robin: 0,1,0,1 one beat per cycle, source 0 first.
    push(8'h10, 1, 0); step(0, 1, 8'h10, 1, 1, 8'h20, 1, 1, 1, 0, 0);
    push(8'h20, 1, 1); step(0, 1, 8'h11, 1, 1, 8'h20, 1, 1, 0, 1, 1);
    push(8'h11, 1, 0); step(0, 1, 8'h11, 1, 1, 8'h21, 1, 1, 1, 0, 1);
    push(8'h21, 1, 1); step(0, 1, 8'h12, 1, 1, 8'h21, 1, 1, 0, 1, 1);

    // Burst lock: src1 3 beats with a bubble; src0 stalled while valid.
    push(8'h30, 0, 1); step(0, 0, 8'h40, 1, 1, 8'h30, 0, 1, 0, 1, 1);
    step(0, 1, 8'h40, 1, 0, 8'h31, 0, 1, 0, 1, 1);
    push(8'h31, 0, 1); step(0, 1, 8'h40, 1, 1, 8'h31, 0, 1, 0, 1, 0);
    push(8'h32, 1, 1); step(0, 1, 8'h40, 1, 1, 8'h32, 1, 1, 0, 1, 1);
    push(8'h40, 1, 0); step(0, 1, 8'h40, 1, 0, 8'h50, 1, 1, 1, 0, 1);

    // Back-pressure: 4 stalled cycles, output held stable.
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 8'h41, 1, 1, 8'h50, 1, 0, 0, 0, 1);
      chk("stall_data", 32'(out_data), 32'h40);
      chk("stall_last", 32'(out_last), 32'd1);
      chk("stall_src", 32'(out_src), 32'd0);
    end
    push(8'h50, 1, 1); step(0, 1, 8'h41, 1, 1, 8'h50, 1, 1, 0, 1, 1);
    push(8'h41, 1, 0); step(0, 1, 8'h41, 1, 0, 8'h51, 1, 1, 1, 0, 1);

    // Single source: 5 back-to-back beats from src0.
    for (int i = 0; i < 5; i++) begin
      push(8'(8'h60 + i), 1, 0);
      step(0, 1, 8'(8'h60 + i), 1, 0, 8'h00, 0, 1, 1, 0, 1);
    end
    step(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 1);
    step(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0);

    // Reset mid-burst: src0 sends 2 of 4 beats, held beat dropped by reset.
    push(8'h70, 0, 0); step(0, 1, 8'h70, 0, 0, 8'h00, 0, 1, 1, 0, 0);
    step(0, 1, 8'h71, 0, 0, 8'h00, 0, 1, 1, 0, 1);
    step(1, 1, 8'h72, 0, 1, 8'h80, 1, 0, 0, 0, 1);
    push(8'h80, 1, 1); step(0, 0, 8'h72, 0, 1, 8'h80, 1, 1, 0, 1, 0);
    chk("post_reset_src", 32'(out_src), 32'd1);
    step(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 1);
    step(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
